// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: definitions shared by the SPI RAM command link (master and
// RAM-side blocks). Holds the opcode constants, frame field widths and the
// master FSM state encoding.
package spi_ram_pkg;

  // Command opcodes, carried in the two MSBs of every frame.
  localparam logic [1:0] WRITE_ADD  = 2'b00;
  localparam logic [1:0] WRITE_DATA = 2'b01;
  localparam logic [1:0] READ_ADD   = 2'b10;
  localparam logic [1:0] READ_DATA  = 2'b11;

  localparam int CMD_W  = 10;  // opcode + payload
  localparam int DATA_W = 8;   // payload / read byte

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_SHIFT,
    ST_TURN,
    ST_READ,
    ST_DEASSERT,
    ST_GUARD
  } state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: half-period counter and SCLK register for the SPI master.
//   clk, rst_n  : system clock, async active-low reset
//   en_i        : counter runs (master is outside IDLE)
//   clr_i       : synchronous clear, pulsed on every phase entry
//   wrap_i      : wrap the counter every half period; low lets it count on
//                 past H (used for the post-frame guard interval)
//   tick_en_i   : a rising SCLK edge is allowed at the end of this low half
//   cnt_o       : current count
//   half_end_o  : last clk of the current half period
//   rise_o      : SCLK goes high on this clk edge
//   fall_o      : SCLK goes low on this clk edge
//   sclk_o      : registered SPI clock, idle low
module spi_sclk_gen #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = $clog2(2 * CLK_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             wrap_i,
  input  logic             tick_en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             half_end_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             sclk_o
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;

  always_comb begin
    half_end_o = en_i && (cnt_q == HALF_LAST);
    // A fall always completes a high half; a rise is only issued when the
    // FSM still has SCLK cycles left in the frame.
    rise_o     = half_end_o && !sclk_q && tick_en_i;
    fall_o     = half_end_o && sclk_q;

    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = (half_end_o && wrap_i) ? '0 : cnt_q + CNT_W'(1);

    sclk_d = sclk_q;
    if (rise_o)
      sclk_d = 1'b1;
    else if (fall_o)
      sclk_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_ram_master.sv
// spi_ram_master: SPI mode-0 initiator for the SPI-attached RAM.
// Sends {op, payload} MSB-first; READ_DATA frames add a turnaround and an
// 8-bit MISO read phase whose byte is returned on rsp_data/rsp_valid.
//   clk, rst_n            : system clock, async active-low reset
//   req_valid/req_ready   : host request handshake (ready only in IDLE)
//   req_op, req_data      : opcode and payload
//   rsp_valid, rsp_data   : one-clk pulse with the read byte (byte held)
//   busy                  : frame in progress (accept .. back in IDLE)
//   sclk, ss_n, mosi, miso: SPI pins
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int TA_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              sclk,
  output logic              ss_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int CNT_W    = $clog2(2 * CLK_DIV);
  localparam int RD_FIRST = CMD_W + TA_CYCLES;  // rises before the first MISO bit
  localparam int N_RD     = RD_FIRST + DATA_W;  // SCLK cycles in a READ_DATA frame
  // DEASSERT takes one clk, so GUARD ends on count 2H-2 to make ss_n high
  // exactly 2H clk before req_ready returns.
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(2 * CLK_DIV - 2);

  state_e              state_q, state_d;
  logic [CMD_W-1:0]    tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic                rd_q, rd_d;
  logic                mosi_q, mosi_d;
  logic                ss_n_q, ss_n_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

  logic [CNT_W-1:0]    cnt;
  logic                half_end, rise, fall, sclk_w;
  logic                in_frame, low_end, tick_en;
  logic [4:0]          n_bits;

  assign in_frame = (state_q == ST_ASSERT) || (state_q == ST_SHIFT) ||
                    (state_q == ST_TURN)   || (state_q == ST_READ);
  assign n_bits   = rd_q ? 5'(N_RD) : 5'(CMD_W);
  // bit_cnt counts rises already issued, so once it reaches the frame
  // length the final low half runs out without another rise.
  assign tick_en  = in_frame && (bit_cnt_q != n_bits);
  assign low_end  = half_end && !sclk_w;

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_sclk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (state_q != ST_IDLE),
    .clr_i      (state_q != state_d),
    .wrap_i     (state_q != ST_GUARD),
    .tick_en_i  (tick_en),
    .cnt_o      (cnt),
    .half_end_o (half_end),
    .rise_o     (rise),
    .fall_o     (fall),
    .sclk_o     (sclk_w)
  );

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bit_cnt_d   = bit_cnt_q;
    rd_d        = rd_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_IDLE: if (req_valid) begin
        state_d   = ST_ASSERT;
        tx_d      = {req_op, req_data};
        mosi_d    = req_op[1];
        bit_cnt_d = '0;
        rd_d      = (req_op == READ_DATA);
      end
      ST_ASSERT: if (low_end) state_d = ST_SHIFT;
      ST_SHIFT: if (low_end && bit_cnt_q == 5'(CMD_W))
        state_d = rd_q ? ST_TURN : ST_DEASSERT;
      ST_TURN: if (low_end && bit_cnt_q == 5'(RD_FIRST)) state_d = ST_READ;
      ST_READ: if (low_end && bit_cnt_q == 5'(N_RD)) begin
        state_d     = ST_DEASSERT;
        rsp_valid_d = 1'b1;
        rsp_data_d  = rx_q;
      end
      ST_DEASSERT: state_d = ST_GUARD;
      ST_GUARD: if (cnt == GUARD_LAST) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // MISO is sampled on the same clk edge that raises SCLK; the first read
    // rise is the one leaving the turnaround.
    if (rise) begin
      bit_cnt_d = bit_cnt_q + 5'd1;
      if (rd_q && bit_cnt_q >= 5'(RD_FIRST))
        rx_d = {rx_q[DATA_W-2:0], miso};
    end
    // Zeros shift in behind the command, so MOSI idles low during the
    // turnaround and read phases.
    if (fall) begin
      tx_d   = {tx_q[CMD_W-2:0], 1'b0};
      mosi_d = tx_q[CMD_W-2];
    end

    ss_n_d = !((state_d == ST_ASSERT) || (state_d == ST_SHIFT) ||
               (state_d == ST_TURN)   || (state_d == ST_READ));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      bit_cnt_q   <= '0;
      rd_q        <= 1'b0;
      mosi_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bit_cnt_q   <= bit_cnt_d;
      rd_q        <= rd_d;
      mosi_q      <= mosi_d;
      ss_n_q      <= ss_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign sclk      = sclk_w;
  assign ss_n      = ss_n_q;
  assign mosi      = mosi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// tb_spi_ram_master: directed bench for spi_ram_master (CLK_DIV=4, TA=2)
// with a behavioural SPI slave that logs each frame and returns a read byte.
module tb_spi_ram_master;
  import spi_ram_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_data = 8'h00;
  logic       miso = 1'b0;
  logic       req_ready, rsp_valid, busy, sclk, ss_n, mosi;
  logic [7:0] rsp_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  spi_ram_master #(.CLK_DIV(4), .TA_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .sclk(sclk), .ss_n(ss_n),
    .mosi(mosi), .miso(miso)
  );

  // Slave model: first 10 rising-edge samples form the command; any MOSI 1
  // after that is flagged; MISO bit7..0 driven after rises 12..19.
  logic [7:0] slv_byte = 8'h00;
  logic [9:0] cap;
  logic       extra;
  int         rise_cnt = 0;
  int         frame_cnt = 0;
  logic [9:0] frame_log [64];
  int         rise_log  [64];
  logic       extra_log [64];

  initial forever begin
    @(negedge ss_n);
    rise_cnt = 0; cap = '0; extra = 1'b0; miso = 1'b0;
    while (1) begin
      @(sclk or ss_n);
      if (ss_n) break;
      if (sclk) begin
        if (rise_cnt < 10) cap = {cap[8:0], mosi};
        else if (mosi) extra = 1'b1;
        rise_cnt++;
      end else if (rise_cnt >= 12 && rise_cnt < 20) begin
        miso = slv_byte[19 - rise_cnt];
      end
    end
    frame_log[frame_cnt] = cap;
    rise_log[frame_cnt]  = rise_cnt;
    extra_log[frame_cnt] = extra;
    frame_cnt++;
    miso = 1'b0;
  end

  // Clock-sampled monitor: ss_n low/high run lengths, ss_n-rise to
  // req_ready gap, rsp_valid pulses and their alignment with ss_n rising.
  int   low_acc = 0, hi_acc = 0, rdy_acc = 0;
  int   last_low = 0, last_high = 0, last_rdy = 0;
  int   rsp_pulses = 0;
  logic rsp_at_rise = 1'b0;
  logic prev_ss = 1'b1;

  always @(posedge clk) begin
    if (!ss_n) begin
      low_acc <= low_acc + 1;
      rdy_acc <= 0;
      if (hi_acc != 0) begin last_high <= hi_acc; hi_acc <= 0; end
    end else begin
      hi_acc <= hi_acc + 1;
      if (low_acc != 0) begin last_low <= low_acc; low_acc <= 0; end
      if (!req_ready) rdy_acc <= rdy_acc + 1;
      else if (rdy_acc != 0) begin last_rdy <= rdy_acc; rdy_acc <= 0; end
    end
    if (rsp_valid) begin
      rsp_pulses  <= rsp_pulses + 1;
      rsp_at_rise <= !prev_ss && ss_n;
    end
    prev_ss <= ss_n;
  end

  task automatic send(input logic [1:0] op, input logic [7:0] d);
    bit ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_data = d;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (busy) begin ok = 1'b1; break; end
    end
    req_valid = 1'b0;
    total_cnt++;
    if (!ok) $display("FAIL accept op=%b: busy got 0, want 1", op);
    else pass_cnt++;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
    total_cnt++;
    if (!ok) $display("FAIL %s_idle: req_ready got 0 after 1000 clk, want 1", tag);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    repeat (3) @(negedge clk);
    obs = {ss_n, sclk, mosi, rsp_valid, req_ready, busy, rsp_data};
    total_cnt++;
    if (obs !== {6'b100010, 8'h00}) $display("FAIL rst_held: got %h want %h", obs, {6'b100010, 8'h00});
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    obs = {ss_n, sclk, mosi, rsp_valid, req_ready, busy, rsp_data};
    total_cnt++;
    if (obs !== {6'b100010, 8'h00}) $display("FAIL rst_idle: got %h want %h", obs, {6'b100010, 8'h00});
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1 obs = {ss_n, sclk, mosi, rsp_valid, req_ready, busy, rsp_data};
    total_cnt++;
    if (obs !== {6'b100010, 8'h00}) $display("FAIL rst_mid_idle: got %h want %h", obs, {6'b100010, 8'h00});
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_add();
    int f0 = frame_cnt;
    int p0 = rsp_pulses;
    send(WRITE_ADD, 8'h3C);
    wait_idle("wa");
    total_cnt++;
    if (frame_log[f0] !== 10'b00_0011_1100) $display("FAIL wa_bits: got %b want %b", frame_log[f0], 10'b00_0011_1100);
    else pass_cnt++;
    total_cnt++;
    if (rise_log[f0] != 10) $display("FAIL wa_rises: got %0d want 10", rise_log[f0]);
    else pass_cnt++;
    total_cnt++;
    if (last_low != 84) $display("FAIL wa_ss_low: got %0d want 84", last_low);
    else pass_cnt++;
    total_cnt++;
    if (rsp_pulses != p0) $display("FAIL wa_no_rsp: got %0d pulses want %0d", rsp_pulses, p0);
    else pass_cnt++;
    total_cnt++;
    if (last_rdy != 8) $display("FAIL wa_ready_gap: got %0d want 8", last_rdy);
    else pass_cnt++;
  endtask

  task automatic test_read();
    int f0 = frame_cnt;
    int p0 = rsp_pulses;
    send(READ_ADD, 8'h12);
    wait_idle("ra");
    total_cnt++;
    if (frame_log[f0] !== {2'b10, 8'h12} || rise_log[f0] != 10)
      $display("FAIL ra_frame: got %b/%0d want %b/10", frame_log[f0], rise_log[f0], {2'b10, 8'h12});
    else pass_cnt++;
    slv_byte = 8'hA5;
    send(READ_DATA, 8'h5A);
    wait_idle("rd");
    total_cnt++;
    if (frame_log[f0+1] !== {2'b11, 8'h5A} || extra_log[f0+1] !== 1'b0)
      $display("FAIL rd_bits: got %b extra=%b want %b extra=0", frame_log[f0+1], extra_log[f0+1], {2'b11, 8'h5A});
    else pass_cnt++;
    total_cnt++;
    if (rise_log[f0+1] != 20) $display("FAIL rd_rises: got %0d want 20", rise_log[f0+1]);
    else pass_cnt++;
    total_cnt++;
    if (last_low != 164) $display("FAIL rd_ss_low: got %0d want 164", last_low);
    else pass_cnt++;
    total_cnt++;
    if (rsp_pulses != p0 + 1 || rsp_at_rise !== 1'b1)
      $display("FAIL rd_rsp_pulse: got %0d pulses at_rise=%b want %0d at_rise=1", rsp_pulses - p0, rsp_at_rise, 1);
    else pass_cnt++;
    total_cnt++;
    if (rsp_data !== 8'hA5) $display("FAIL rd_data: got %h want a5", rsp_data);
    else pass_cnt++;
    send(WRITE_DATA, 8'h77);
    wait_idle("wd");
    total_cnt++;
    if (frame_log[f0+2] !== {2'b01, 8'h77}) $display("FAIL wd_bits: got %b want %b", frame_log[f0+2], {2'b01, 8'h77});
    else pass_cnt++;
    total_cnt++;
    if (rsp_data !== 8'hA5 || rsp_pulses != p0 + 1)
      $display("FAIL wd_rsp_hold: got %h/%0d want a5/%0d", rsp_data, rsp_pulses, p0 + 1);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int   f0 = frame_cnt;
    int   acc = 0;
    logic prev = busy;
    @(negedge clk);
    req_valid = 1'b1; req_op = WRITE_DATA; req_data = 8'h55;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (busy && !prev) begin
        acc++;
        if (acc == 2) break;
        req_op = WRITE_ADD; req_data = 8'h01;
      end
      prev = busy;
    end
    req_valid = 1'b0;
    total_cnt++;
    if (acc != 2) $display("FAIL b2b_accepts: got %0d want 2", acc);
    else pass_cnt++;
    wait_idle("b2b");
    repeat (40) @(negedge clk);
    total_cnt++;
    if (frame_cnt != f0 + 2) $display("FAIL b2b_frames: got %0d want 2", frame_cnt - f0);
    else pass_cnt++;
    total_cnt++;
    if (frame_log[f0] !== {2'b01, 8'h55} || frame_log[f0+1] !== {2'b00, 8'h01})
      $display("FAIL b2b_bits: got %b,%b want %b,%b", frame_log[f0], frame_log[f0+1], {2'b01, 8'h55}, {2'b00, 8'h01});
    else pass_cnt++;
    total_cnt++;
    if (last_high != 9) $display("FAIL b2b_ss_high: got %0d want 9", last_high);
    else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    int f0 = frame_cnt;
    int p0 = rsp_pulses;
    slv_byte = 8'h3E;
    send(READ_DATA, 8'h96);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
      req_valid = i[0];
      req_op    = i[2:1];
      req_data  = 8'(i * 37);
    end
    req_valid = 1'b0;
    wait_idle("bi");
    repeat (60) @(negedge clk);
    total_cnt++;
    if (frame_cnt != f0 + 1) $display("FAIL bi_frames: got %0d want 1", frame_cnt - f0);
    else pass_cnt++;
    total_cnt++;
    if (frame_log[f0] !== {2'b11, 8'h96} || extra_log[f0] !== 1'b0 || rise_log[f0] != 20)
      $display("FAIL bi_bits: got %b/%b/%0d want %b/0/20", frame_log[f0], extra_log[f0], rise_log[f0], {2'b11, 8'h96});
    else pass_cnt++;
    total_cnt++;
    if (rsp_data !== 8'h3E || rsp_pulses != p0 + 1)
      $display("FAIL bi_rsp: got %h/%0d want 3e/%0d", rsp_data, rsp_pulses - p0, 1);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int          p0 = rsp_pulses;
    int          f1;
    bit          ok = 1'b0;
    logic [13:0] obs;
    slv_byte = 8'hC3;
    send(READ_DATA, 8'hF0);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rise_cnt == 15) begin ok = 1'b1; break; end
    end
    total_cnt++;
    if (!ok) $display("FAIL mid_reach_read: rise_cnt got %0d want 15", rise_cnt);
    else pass_cnt++;
    #1 rst_n = 1'b0;
    #1 obs = {ss_n, sclk, mosi, rsp_valid, req_ready, busy, rsp_data};
    total_cnt++;
    if (obs !== {6'b100010, 8'h00}) $display("FAIL mid_rst_outs: got %h want %h", obs, {6'b100010, 8'h00});
    else pass_cnt++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (rsp_pulses != p0 || rsp_data !== 8'h00)
      $display("FAIL mid_no_rsp: got %0d/%h want 0/00", rsp_pulses - p0, rsp_data);
    else pass_cnt++;
    f1 = frame_cnt;
    send(WRITE_ADD, 8'hFF);
    wait_idle("post");
    total_cnt++;
    if (frame_log[f1] !== {2'b00, 8'hFF} || rise_log[f1] != 10 || last_low != 84)
      $display("FAIL post_frame: got %b/%0d/%0d want %b/10/84", frame_log[f1], rise_log[f1], last_low, {2'b00, 8'hFF});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_add();
    test_read();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/spi_ram_master.md
# spi_ram_master

SPI initiator for the SPI-attached RAM command interface. It accepts 10-bit RAM commands from a local host: a 2-bit opcode plus an 8-bit payload. It serialises each command MSB-first on MOSI as SPI mode 0 frames. For READ_DATA commands it runs a turnaround phase, then shifts the returned byte in from MISO and hands it to the host. It sits on the host/FPGA side of the link, opposite the SPI slave + RAM.

## Interface
- CLK_DIV, 4: clk cycles per SCLK half-period (H); legal ≥2.
- TA_CYCLES, 2: idle SCLK cycles between the last command bit and the first MISO bit, READ_DATA only; legal ≥1.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  host request valid.
- req_ready  out  1  high only in IDLE; a request is accepted on valid&&ready.
- req_op  in  2  00 WRITE_ADD, 01 WRITE_DATA, 10 READ_ADD, 11 READ_DATA.
- req_data  in  8  payload (address or data; ignored content for READ_DATA but still sent).
- rsp_valid  out  1  one-clk pulse, read byte available.
- rsp_data  out  8  last read byte; held until the next READ_DATA completes.
- busy  out  1  high from accept until return to IDLE.
- sclk  out  1  SPI clock, idle low.
- ss_n  out  1  slave select, active-low.
- mosi  out  1  serial command out.
- miso  in  1  serial read data in.

## Operation
- Accept: latch {req_op, req_data} into a 10-bit shift register. N = 10 SCLK cycles, or 10+TA_CYCLES+8 for opcode 11.
- FSM states and transitions:
  - IDLE → ASSERT on accept.
  - ASSERT (1 H): ss_n low, sclk low, mosi = bit 9.
  - SHIFT (10 SCLK cycles) → TURN if opcode 11, else DEASSERT.
  - TURN (TA_CYCLES SCLK cycles): mosi driven 0.
  - READ (8 SCLK cycles): mosi driven 0.
  - DEASSERT → GUARD: ss_n high, sclk low.
  - GUARD (2 H) → IDLE.
- SCLK cycle: high half (H), then low half (H).
- Slave samples mosi on the sclk rising edge. Master advances mosi to the next bit at the start of the low half.
- READ: master samples miso on the clk edge where sclk goes 1, shifting left (MSB first). rsp_data updates and rsp_valid pulses on the clk ss_n rises.
- Opcodes 00/01/10 produce no MISO phase and no rsp_valid.
- req_valid while busy is ignored. Input changes while busy have no effect on the current frame.
- Reset values: ss_n 1, sclk 0, mosi 0, rsp_valid 0, rsp_data 0x00, busy 0, req_ready 1, state IDLE.
- Reset mid-frame: all outputs return to reset values immediately (async). No rsp_valid is issued. The slave drops the partial frame on ss_n rising.

## Timing
- H = CLK_DIV clk cycles. One SCLK cycle = 2·CLK_DIV clk cycles.
- ss_n is low for (1 + 2N)·H clk cycles.
- Write/address frames with CLK_DIV=4: ss_n low 84 clk.
- READ_DATA with CLK_DIV=4, TA=2: N=20, ss_n low 164 clk.
- Accept → ss_n low: 1 clk.
- ss_n high → req_ready high: 2H clk. Minimum ss_n high time between frames: 2H + 1 clk.
- sclk, ss_n and mosi are registered outputs, glitch-free.
- Half-period counter runs only outside IDLE. It is reset to 0 on every phase entry.
- Bit counter is 5 bits, counts SCLK rising edges within the frame. It never wraps inside a frame.

## Structure
- Shared package spi_ram_pkg:
  - opcode constants WRITE_ADD/WRITE_DATA/READ_ADD/READ_DATA (2'b00..2'b11);
  - CMD_W=10, DATA_W=8;
  - the state encoding. The RAM-side blocks use the same opcode constants.
- Sub-module spi_sclk_gen: half-period counter, enabled by FSM, emits rise/fall ticks and drives sclk.
- FSM, shift registers and response logic live in spi_ram_master.

## Test plan
- Reset: assert rst_n low mid-idle → ss_n=1, sclk=0, mosi=0, rsp_valid=0, rsp_data=0x00, req_ready=1.
- WRITE_ADD 0x3C (CLK_DIV=4) → slave model captures 10'b00_0011_1100 on 10 rising edges; ss_n low 84 clk; no rsp_valid; req_ready returns 8 clk after ss_n rises.
- READ_ADD 0x12 then READ_DATA, slave model drives 0xA5 after turnaround → 20 rising edges; rsp_valid single pulse with rsp_data=0xA5 on ss_n rise; rsp_data holds through a following WRITE_DATA 0x77.
- Back-to-back: req_valid held high with WRITE_DATA 0x55 then WRITE_ADD 0x01 → second accepted only when req_ready=1; ss_n high ≥9 clk between frames; both frames bit-exact.
- Reset mid-frame: rst_n low during READ bit 5 → ss_n=1 and sclk=0 immediately; no rsp_valid; rsp_data=0x00. A subsequent WRITE_ADD 0xFF is sent cleanly.
- Busy-ignore: toggle req_valid/req_data during a READ_DATA frame → no extra frame; transmitted bits unchanged.
